uart_rx_ctrl: RTL and testbench

- MMIO-side controller for the UART receive core.
- Consumes bytes from the receiver's valid/ack handshake and buffers them in a DEPTH-entry FIFO.
- Exposes DATA/STATUS/CTRL registers to the CPU load/store path and raises a level interrupt on fill threshold or overrun.
- Sits between the UART receive core and the MMIO decoder.

---
 rtl/uart_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// MMIO receive controller: acks bytes from the UART receive core into a FIFO and
// exposes DATA/STATUS/CTRL registers plus a level interrupt on threshold or overrun.
module uart_rx_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ack,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_irq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    A_DATA   = 2'd0,
    A_STATUS = 2'd1,
    A_CTRL   = 2'd2,
    A_RSVD   = 2'd3
  } addr_e;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             ack_q, ack_d;
  logic             rx_en_q, rx_en_d;
  logic             irq_en_q, irq_en_d;
  logic [7:0]       thr_q, thr_d;
  logic             irq_q, irq_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        empty, full, capture, rd_stb, wr_stb;
  logic        pop, push, flush, w1c, ovr_set, irq_cond;
  logic [7:0]  thr_eff;
  logic [31:0] status_w, ctrl_w;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    // A byte still presented during its own ack cycle is the same byte.
    capture = i_rx_valid & ~ack_q;
    rd_stb  = i_sel & ~i_we;
    wr_stb  = i_sel & i_we;
    pop     = rd_stb & (i_addr == A_DATA) & ~empty;
    flush   = wr_stb & (i_addr == A_CTRL) & i_wdata[2];
    w1c     = wr_stb & (i_addr == A_STATUS) & i_wdata[2];
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    push    = capture & rx_en_q & (~full | pop) & ~flush;
    ovr_set = capture & rx_en_q & full & ~pop & ~flush;

    thr_eff  = (thr_q == 8'd0) ? 8'd1 : thr_q;
    irq_cond = irq_en_q & ((9'(count_q) >= {1'b0, thr_eff}) | ovr_q);

    status_w = {16'h0, 8'(count_q), 4'h0, irq_cond, ovr_q, full, ~empty};
    ctrl_w   = {16'h0, thr_q, 5'h0, 1'b0, irq_en_q, rx_en_q};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovr_d    = ovr_set | (ovr_q & ~w1c);
    ack_d    = capture;
    rx_en_d  = rx_en_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    if (wr_stb && i_addr == A_CTRL) begin
      rx_en_d  = i_wdata[0];
      irq_en_d = i_wdata[1];
      thr_d    = i_wdata[15:8];
    end
    irq_d    = irq_cond;
    rvalid_d = rd_stb;
    rdata_d  = rdata_q;
    if (rd_stb) begin
      case (addr_e'(i_addr))
        A_DATA:   rdata_d = empty ? 32'h0 : {1'b1, 23'h0, mem_q[rd_ptr_q]};
        A_STATUS: rdata_d = status_w;
        A_CTRL:   rdata_d = ctrl_w;
        default:  rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ack_q    <= 1'b0;
      rx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
      thr_q    <= 8'd1;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ack_q    <= ack_d;
      rx_en_q  <= rx_en_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is not reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_rx_data;
  end

  assign o_rx_ack = ack_q;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_irq    = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed steps then random traffic, all checked against
// a queue-based model of the register/FIFO behaviour.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ack;
  logic        sel = 1'b0;
  logic        we_s = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ack(rx_ack), .i_sel(sel), .i_we(we_s), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_irq(irq)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  mq[$];
  bit          m_ovr, m_rx_en, m_irq_en, m_ack, m_irq;
  logic [7:0]  m_thr;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    mq.delete();
    m_ovr = 0; m_rx_en = 1; m_irq_en = 0; m_thr = 8'd1;
    m_ack = 0; m_irq = 0; m_rdata = 32'h0;
  endfunction

  function automatic bit m_cond();
    int t;
    t = (m_thr == 8'd0) ? 1 : int'(m_thr);
    return m_irq_en && ((mq.size() >= t) || m_ovr);
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(mq.size()), 4'h0, m_cond(), m_ovr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  // One clock of stimulus; the model is advanced from its pre-edge state.
  task automatic step(input string tag, input bit rv, input logic [7:0] rb,
                      input bit acc, input bit we, input logic [1:0] a, input logic [31:0] wd);
    bit cap, rd, pop_ok, full0, do_flush, set_ovr, nxt_irq;
    @(negedge clk);
    rx_valid = rv; rx_data = rb; sel = acc; we_s = we; addr = a; wdata = wd;
    cap = rv && !m_ack;
    rd = acc && !we;
    full0 = (mq.size() == DEPTH);
    pop_ok = 0;
    set_ovr = 0;
    if (rd) begin
      case (a)
        2'd0: begin
          m_rdata = 32'h0;
          if (mq.size() != 0) begin m_rdata = {1'b1, 23'h0, mq[0]}; pop_ok = 1; end
        end
        2'd1: m_rdata = m_status();
        2'd2: m_rdata = {16'h0, m_thr, 5'h0, 1'b0, m_irq_en, m_rx_en};
        default: m_rdata = 32'h0;
      endcase
    end
    nxt_irq = m_cond();
    do_flush = acc && we && a == 2'd2 && wd[2];
    if (pop_ok) void'(mq.pop_front());
    if (cap && m_rx_en && !do_flush) begin
      if (!full0 || pop_ok) mq.push_back(rb);
      else set_ovr = 1;
    end
    if (acc && we && a == 2'd1 && wd[2]) m_ovr = 0;
    if (set_ovr) m_ovr = 1;
    if (acc && we && a == 2'd2) begin
      m_rx_en = wd[0]; m_irq_en = wd[1]; m_thr = wd[15:8];
      if (wd[2]) mq.delete();
    end
    m_ack = cap;
    @(posedge clk);
    #1;
    chk({tag, ":ack"}, 32'(rx_ack), 32'(cap));
    chk({tag, ":rvalid"}, 32'(rvalid), 32'(rd));
    chk({tag, ":rdata"}, rdata, m_rdata);
    chk({tag, ":irq"}, 32'(irq), 32'(nxt_irq));
    m_irq = nxt_irq;
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    step(tag, 1, b, 0, 0, 2'd0, 32'h0);
    step({tag, "_hold"}, 1, b, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [1:0] a);
    step(tag, 0, 8'h0, 1, 0, a, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] d);
    step(tag, 0, 8'h0, 1, 1, a, d);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) rd("drain", 2'd0);
  endtask

  initial begin
    bit rv, acc, we;
    logic [1:0] a;
    logic [31:0] wd;
    m_reset();
    #12;
    chk("rst_ack", 32'(rx_ack), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    rd("rst_status", 2'd1);
    chk("rst_status_const", rdata, 32'h0000_0000);
    rd("rst_ctrl", 2'd2);
    chk("rst_ctrl_const", rdata, 32'h0000_0101);

    send("rx_a5", 8'hA5);
    send("rx_3c", 8'h3C);
    rd("st2", 2'd1);
    chk("st2_const", rdata, 32'h0000_0201);
    rd("data_a5", 2'd0);
    chk("data_a5_const", rdata, 32'h8000_00A5);
    rd("data_3c", 2'd0);
    chk("data_3c_const", rdata, 32'h8000_003C);
    rd("data_empty", 2'd0);
    chk("data_empty_const", rdata, 32'h0);
    wr("data_wr_ign", 2'd0, 32'hFFFF_FFFF);
    rd("rsvd", 2'd3);

    for (int i = 0; i <= DEPTH; i++) send("fill", 8'(i));
    rd("st_full", 2'd1);
    chk("st_full_const", rdata, 32'h0000_1007);
    for (int i = 0; i < DEPTH; i++) rd("rd_full", 2'd0);
    rd("rd_lost", 2'd0);
    wr("w1c", 2'd1, 32'h4);
    rd("st_w1c", 2'd1);
    chk("st_w1c_const", rdata, 32'h0);

    wr("ctrl303", 2'd2, 32'h0000_0303);
    send("thr1", 8'h11);
    send("thr2", 8'h22);
    send("thr3", 8'h33);
    step("thr_idle", 0, 8'h0, 0, 0, 2'd0, 32'h0);
    chk("thr_irq_hi", 32'(irq), 32'h1);
    rd("thr_pop", 2'd0);
    step("thr_idle2", 0, 8'h0, 0, 0, 2'd0, 32'h0);
    chk("thr_irq_lo", 32'(irq), 32'h0);
    drain();

    wr("ctrl101", 2'd2, 32'h0000_0101);
    for (int i = 0; i < DEPTH; i++) send("fill2", 8'(8'h40 + i));
    step("full_pushpop", 1, 8'hEE, 1, 0, 2'd0, 32'h0);
    chk("full_pushpop_data", rdata, 32'h8000_0040);
    step("full_pushpop_hold", 1, 8'hEE, 0, 0, 2'd0, 32'h0);
    rd("st_pushpop", 2'd1);
    chk("st_pushpop_const", rdata, 32'h0000_1003);
    drain();

    send("pre_flush", 8'h55);
    step("flush_cap", 1, 8'h77, 1, 1, 2'd2, 32'h0000_0105);
    step("flush_hold", 1, 8'h77, 0, 0, 2'd0, 32'h0);
    rd("ctrl_flush", 2'd2);
    chk("ctrl_flush_const", rdata, 32'h0000_0101);
    rd("st_flush", 2'd1);
    chk("st_flush_const", rdata, 32'h0);
    wr("rx_dis", 2'd2, 32'h0000_0100);
    send("dis1", 8'h9A);
    send("dis2", 8'h9B);
    rd("st_dis", 2'd1);
    chk("st_dis_const", rdata, 32'h0);
    wr("rx_en", 2'd2, 32'h0000_0101);

    for (int i = 0; i < 500; i++) begin
      rv = ($urandom_range(0, 2) != 0);
      acc = ($urandom_range(0, 2) == 0);
      we = $urandom_range(0, 1) == 1;
      a = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (acc && we && a == 2'd2)
        wd = {16'h0, 8'($urandom_range(0, 20)), 5'h0,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) != 0)};
      step("rand", rv, 8'($urandom), acc, we, a, wd);
    end

    send("pre_rst1", 8'hC1);
    send("pre_rst2", 8'hC2);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hC3; sel = 1'b0;
    #2 rstn = 1'b0;
    #1;
    m_reset();
    chk("arst_ack", 32'(rx_ack), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rx_valid = 1'b0;
    rstn = 1'b1;
    rd("arst_status", 2'd1);
    chk("arst_status_const", rdata, 32'h0);
    rd("arst_data", 2'd0);
    chk("arst_data_const", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
